// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger match-level control logic.
package frogger_pkg;

  localparam int SCORE_W = 4;

  typedef enum logic [1:0] {
    PLAY,
    ROUND_END,
    FLASH,
    HOLD
  } win_state_t;

endpackage

// File: rtl/winner_sequencer_flash_timer.sv
// Half-period counter for blinking displays: counts 0..TICKS-1 while enabled
// and raises tc for one cycle on the last count. Disabling it rewinds to 0.
module flash_timer #(
  parameter int TICKS = 12_500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/winner_sequencer.sv
// Match controller: tallies round wins, latches the match winner, flashes the
// winner display and waits for a restart press before starting a new match.
module winner_sequencer
  import frogger_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int FLASH_TICKS = 12_500_000,
  parameter int FLASH_COUNT = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               p1_goal,
  input  logic               p2_goal,
  input  logic               restart_btn,
  output logic               game_run,
  output logic               round_restart,
  output logic               f1,
  output logic               f2,
  output logic               disp_clear,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score
);

  localparam int HALF_W = $clog2(2 * FLASH_COUNT + 1);
  localparam logic [HALF_W-1:0]  LAST_HALF = HALF_W'(2 * FLASH_COUNT - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

  win_state_t         state;
  logic [HALF_W-1:0]  half_cnt;
  logic               flash_tc;
  logic [SCORE_W-1:0] p1_next;
  logic [SCORE_W-1:0] p2_next;

  assign p1_next = p1_score + 1'b1;
  assign p2_next = p2_score + 1'b1;

  flash_timer #(
    .TICKS(FLASH_TICKS)
  ) u_flash_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (state == FLASH),
    .tc     (flash_tc)
  );

  // Player 1 wins ties so the latched winner agrees with the display's f1 priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= PLAY;
      p1_score      <= '0;
      p2_score      <= '0;
      f1            <= 1'b0;
      f2            <= 1'b0;
      disp_clear    <= 1'b1;
      game_run      <= 1'b1;
      round_restart <= 1'b0;
      half_cnt      <= '0;
    end else begin
      case (state)
        PLAY: begin
          game_run      <= 1'b1;
          round_restart <= 1'b0;
          disp_clear    <= 1'b1;
          if (p1_goal) begin
            p1_score <= p1_next;
            game_run <= 1'b0;
            if (p1_next == WIN_VAL) begin
              f1         <= 1'b1;
              disp_clear <= 1'b0;
              state      <= FLASH;
            end else begin
              round_restart <= 1'b1;
              state         <= ROUND_END;
            end
          end else if (p2_goal) begin
            p2_score <= p2_next;
            game_run <= 1'b0;
            if (p2_next == WIN_VAL) begin
              f2         <= 1'b1;
              disp_clear <= 1'b0;
              state      <= FLASH;
            end else begin
              round_restart <= 1'b1;
              state         <= ROUND_END;
            end
          end
        end
        ROUND_END: begin
          round_restart <= 1'b0;
          game_run      <= 1'b1;
          state         <= PLAY;
        end
        FLASH: begin
          if (flash_tc) begin
            if (half_cnt == LAST_HALF) begin
              half_cnt   <= '0;
              disp_clear <= 1'b0;
              state      <= HOLD;
            end else begin
              half_cnt   <= half_cnt + 1'b1;
              disp_clear <= ~disp_clear;
            end
          end
        end
        HOLD: begin
          // game_run rises one cycle later, once PLAY has dropped round_restart.
          if (restart_btn) begin
            p1_score      <= '0;
            p2_score      <= '0;
            f1            <= 1'b0;
            f2            <= 1'b0;
            disp_clear    <= 1'b1;
            round_restart <= 1'b1;
            state         <= PLAY;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_winner_sequencer.sv
// Self-checking bench for winner_sequencer: directed scenarios with literal
// expectations, then randomized traffic compared every cycle to a match model.
module tb_winner_sequencer;

  localparam int WIN = 3;
  localparam int FT  = 4;
  localparam int FC  = 2;

  localparam int M_PLAY  = 0;
  localparam int M_RE    = 1;
  localparam int M_FLASH = 2;
  localparam int M_HOLD  = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       p1_goal = 1'b0;
  logic       p2_goal = 1'b0;
  logic       restart_btn = 1'b0;
  logic       game_run;
  logic       round_restart;
  logic       f1;
  logic       f2;
  logic       disp_clear;
  logic [3:0] p1_score;
  logic [3:0] p2_score;

  int errors = 0;
  int checks = 0;

  winner_sequencer #(
    .WIN_SCORE  (WIN),
    .FLASH_TICKS(FT),
    .FLASH_COUNT(FC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .p1_goal      (p1_goal),
    .p2_goal      (p2_goal),
    .restart_btn  (restart_btn),
    .game_run     (game_run),
    .round_restart(round_restart),
    .f1           (f1),
    .f2           (f2),
    .disp_clear   (disp_clear),
    .p1_score     (p1_score),
    .p2_score     (p2_score)
  );

  always #5 clk = ~clk;

  // Match model: phase, scores, winner, and cycles spent flashing.
  int m_phase = M_PLAY;
  int m_p1 = 0;
  int m_p2 = 0;
  int m_f1 = 0;
  int m_f2 = 0;
  int m_age = 0;
  int m_gr = 1;
  int m_rr = 0;
  int m_dc = 1;

  task automatic model_reset();
    m_phase = M_PLAY;
    m_p1 = 0; m_p2 = 0; m_f1 = 0; m_f2 = 0; m_age = 0;
    m_gr = 1; m_rr = 0; m_dc = 1;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      case (m_phase)
        M_PLAY: begin
          m_rr = 0; m_gr = 1; m_dc = 1;
          if (p1_goal || p2_goal) begin
            m_gr = 0;
            if (p1_goal) m_p1++; else m_p2++;
            if (m_p1 == WIN || m_p2 == WIN) begin
              m_f1 = (m_p1 == WIN) ? 1 : 0;
              m_f2 = (m_p2 == WIN) ? 1 : 0;
              m_dc = 0; m_age = 0; m_phase = M_FLASH;
            end else begin
              m_rr = 1; m_phase = M_RE;
            end
          end
        end
        M_RE: begin
          m_rr = 0; m_gr = 1; m_phase = M_PLAY;
        end
        M_FLASH: begin
          m_age++;
          if (m_age == 2 * FC * FT) begin
            m_dc = 0; m_phase = M_HOLD;
          end else begin
            m_dc = (m_age / FT) % 2;
          end
        end
        default: begin
          if (restart_btn) begin
            m_p1 = 0; m_p2 = 0; m_f1 = 0; m_f2 = 0;
            m_dc = 1; m_rr = 1; m_phase = M_PLAY;
          end
        end
      endcase
    end
  end

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check_output("game_run", int'(game_run), m_gr);
    check_output("round_restart", int'(round_restart), m_rr);
    check_output("f1", int'(f1), m_f1);
    check_output("f2", int'(f2), m_f2);
    check_output("disp_clear", int'(disp_clear), m_dc);
    check_output("p1_score", int'(p1_score), m_p1);
    check_output("p2_score", int'(p2_score), m_p2);
  end

  // Drive inputs for exactly one clock edge, then release them.
  task automatic apply_stimulus(input logic g1, input logic g2, input logic rb);
    p1_goal = g1; p2_goal = g2; restart_btn = rb;
    @(negedge clk); #1;
    p1_goal = 1'b0; p2_goal = 1'b0; restart_btn = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  initial begin
    #200_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end by 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int dc_seq[16];
    reset_n = 1'b0;
    idle(3);
    check_output("rst_p1", int'(p1_score), 0);
    check_output("rst_p2", int'(p2_score), 0);
    check_output("rst_f", int'({f1, f2}), 0);
    check_output("rst_dc", int'(disp_clear), 1);
    check_output("rst_gr", int'(game_run), 1);
    check_output("rst_rr", int'(round_restart), 0);
    reset_n = 1'b1;
    idle(1);

    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("t2_p1", int'(p1_score), 1);
    check_output("t2_rr", int'(round_restart), 1);
    check_output("t2_gr", int'(game_run), 0);
    idle(1);
    check_output("t2_rr_end", int'(round_restart), 0);
    check_output("t2_gr_back", int'(game_run), 1);

    apply_stimulus(1'b1, 1'b1, 1'b0);
    check_output("t3_p1", int'(p1_score), 2);
    check_output("t3_p2", int'(p2_score), 0);
    idle(1);

    for (int g = 0; g < 3; g++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0);
      if (g < 2) idle(1);
    end
    check_output("t4_f2", int'(f2), 1);
    check_output("t4_f1", int'(f1), 0);
    for (int i = 0; i < 16; i++) begin
      dc_seq[i] = int'(disp_clear);
      p1_goal = 1'($urandom_range(0, 1));
      p2_goal = 1'($urandom_range(0, 1));
      restart_btn = (i % 5 == 2) ? 1'b1 : 1'b0;
      @(negedge clk); #1;
    end
    p1_goal = 1'b0; p2_goal = 1'b0; restart_btn = 1'b0;
    for (int i = 0; i < 16; i++)
      check_output($sformatf("t4_dc[%0d]", i), dc_seq[i], (i / 4) % 2);
    check_output("t4_hold_dc", int'(disp_clear), 0);
    check_output("t4_hold_p2", int'(p2_score), 3);
    check_output("t4_hold_p1", int'(p1_score), 2);
    idle(2);
    check_output("t4_hold_dc2", int'(disp_clear), 0);

    apply_stimulus(1'b0, 1'b0, 1'b1);
    check_output("t5_rr", int'(round_restart), 1);
    check_output("t5_p2", int'(p2_score), 0);
    check_output("t5_f2", int'(f2), 0);
    check_output("t5_dc", int'(disp_clear), 1);
    check_output("t5_gr_low", int'(game_run), 0);
    idle(1);
    check_output("t5_gr", int'(game_run), 1);
    check_output("t5_rr_end", int'(round_restart), 0);

    for (int g = 0; g < 3; g++) begin
      apply_stimulus(1'b1, 1'b0, 1'b0);
      if (g < 2) idle(1);
    end
    idle(3);
    check_output("t6_in_flash_f1", int'(f1), 1);
    reset_n = 1'b0;
    #1;
    check_output("t6_rst_f1", int'(f1), 0);
    check_output("t6_rst_p1", int'(p1_score), 0);
    check_output("t6_rst_dc", int'(disp_clear), 1);
    check_output("t6_rst_gr", int'(game_run), 1);
    @(negedge clk); #1;
    reset_n = 1'b1;
    idle(1);
    apply_stimulus(1'b1, 1'b0, 1'b0);
    check_output("t6_goal_p1", int'(p1_score), 1);
    idle(1);

    for (int i = 0; i < 1500; i++) begin
      p1_goal = ($urandom_range(0, 3) == 0);
      p2_goal = ($urandom_range(0, 3) == 0);
      restart_btn = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      @(negedge clk); #1;
    end
    p1_goal = 1'b0; p2_goal = 1'b0; restart_btn = 1'b0; reset_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/winner_sequencer.md
# winner_sequencer

Match-level controller for the Frogger game. Counts round wins for two players, decides the match winner, and drives the winner display's select inputs (`f1`, `f2`) and its clear input. It produces a flashing winner screen, then holds until a restart press and resets the match. It sits between the playfield logic, which raises goal pulses, and the winner-display block.

## Interface

Parameters:
- `WIN_SCORE`, default 3: round wins needed to take the match (1..15).
- `FLASH_TICKS`, default 12_500_000: clock cycles per flash half-period.
- `FLASH_COUNT`, default 3: number of blank/show flash pairs before HOLD.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `p1_goal`  in  1: single-cycle pulse; player 1 frog reached home. Synchronised upstream.
- `p2_goal`  in  1: single-cycle pulse; player 2 frog reached home.
- `restart_btn`  in  1: single-cycle pulse, already debounced and edge-detected.
- `game_run`  out  1: high while the playfield may advance.
- `round_restart`  out  1: one-cycle pulse; playfield returns frogs and obstacles to start.
- `f1`  out  1: player 1 winner select to the display.
- `f2`  out  1: player 2 winner select to the display.
- `disp_clear`  out  1: drives the display's clear input; high means blank.
- `p1_score`  out  4: player 1 round wins.
- `p2_score`  out  4: player 2 round wins.

## Operation

States: PLAY, ROUND_END, FLASH, HOLD.

**Reset**
- Reset values: state PLAY, scores 0, `f1`=`f2`=0, `disp_clear`=1, `game_run`=1, `round_restart`=0, all counters 0.

**PLAY**
- `game_run`=1, `disp_clear`=1.
- A goal pulse increments that player's score.
- If both goal pulses arrive in the same cycle, only player 1 is credited. This matches the display's f1 priority.
- If the incremented score equals `WIN_SCORE`:
  - latch winner: `f1`=1 for player 1, `f2`=1 for player 2. At most one is ever high.
  - go to FLASH.
- Otherwise go to ROUND_END.
- Scores never exceed `WIN_SCORE`.

**ROUND_END**
- Lasts one cycle.
- `round_restart`=1, `game_run`=0.
- Next state is PLAY.

**FLASH**
- `game_run`=0.
- The half-period counter counts 0..`FLASH_TICKS`-1.
- At each terminal count, `disp_clear` toggles. The first half-period is shown, with `disp_clear`=0.
- After `2*FLASH_COUNT` half-periods, go to HOLD.
- `restart_btn` is ignored in FLASH.

**HOLD**
- `disp_clear`=0, so the winner stays shown. `game_run`=0.
- On `restart_btn`:
  - clear scores and `f1`/`f2`;
  - set `disp_clear`=1;
  - pulse `round_restart` for one cycle;
  - go to PLAY.

**Input filtering**
- Goal pulses are ignored outside PLAY.

**Mid-operation reset**
- `reset_n` low in any state returns everything to reset values immediately.

## Timing

All outputs are registered.

**Goal pulse in PLAY, cycle N**
- Score updates at N+1.
- Non-winning goal: `round_restart` high during cycle N+1 only, `game_run` low during N+1, back to PLAY at N+2.
- Winning goal: `f1`/`f2` valid and `disp_clear`=0 from N+1. `game_run` low from N+1.

**FLASH**
- Each half-period is exactly `FLASH_TICKS` cycles.
- Total FLASH duration is `2*FLASH_COUNT*FLASH_TICKS` cycles. HOLD is entered on the following edge.

**Restart from HOLD, cycle N**
- At N+1: `round_restart`=1, scores 0, `f1`=`f2`=0, `disp_clear`=1.
- At N+2: `game_run`=1.

**Counter widths**
- The flash counter width is `$clog2(FLASH_TICKS)`.
- The flash pair counter width is `$clog2(2*FLASH_COUNT+1)`.

## Structure

- Package `frogger_pkg` holds:
  - the state enum `win_state_t` (PLAY, ROUND_END, FLASH, HOLD);
  - the constant `SCORE_W`=4.
- One natural sub-module: `flash_timer`. It is a parameterised half-period counter with enable and terminal-count pulse, reusable by other blinking displays.
- The FSM and score registers live in the top module.

## Test plan

Test plan uses `WIN_SCORE`=3, `FLASH_TICKS`=4, `FLASH_COUNT`=2.

1. **Reset:** hold `reset_n`=0 for 3 cycles → scores 0, `f1`=`f2`=0, `disp_clear`=1, `game_run`=1, `round_restart`=0.
2. **Single round win:** `p1_goal` pulse → `p1_score`=1 next cycle, `round_restart` high exactly one cycle, `game_run` low that cycle, state back to PLAY.
3. **Simultaneous goals:** `p1_goal`=`p2_goal`=1 in the same cycle → `p1_score`+1, `p2_score` unchanged.
4. **Match win:** player 2 reaches 3 goals → `f2`=1, `f1`=0. `disp_clear` sequence is 0×4, 1×4, 0×4, 1×4, then held at 0 in HOLD. Goal pulses during this period change nothing.
5. **Restart:** `restart_btn` during FLASH is ignored. `restart_btn` in HOLD → `round_restart` pulse, scores 0, `f2`=0, `disp_clear`=1, `game_run`=1 one cycle later.
6. **Reset mid-flash:** `reset_n` low during FLASH → immediate return to reset values. A following goal is counted normally.
